countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
//  Countdown-timer core: produces the BCD count q and the status flags is_pause, is_restart and
//  is_setting that the LED and display stages consume. Inputs are one-cycle button pulses
//  (already debounced and one-pulsed) and a 1 Hz tick. Supports a preset setting mode and
//  run/pause/restart control.
// PARAMETERS
//  DIGITS     2      number of BCD digits; count width W = 4*DIGITS
//  INIT_VALUE 8'h30  BCD preset loaded at reset; nonzero, <= MAX_VALUE
//  MAX_VALUE  8'h99  largest preset reachable in setting mode (BCD)
// PORTS
//  clk          in   1  system clock; all state on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  tick_1hz     in   1  one-cycle pulse, once per second
//  btn_start    in   1  one-cycle pulse: run/pause toggle
//  btn_restart  in   1  one-cycle pulse: reload preset, return to IDLE
//  btn_set      in   1  one-cycle pulse: enter/exit setting mode
//  btn_inc      in   1  one-cycle pulse: preset +1 (SET state only)
//  q            out  W  current BCD count (preset while in SET)
//  is_pause     out  1  1 in IDLE, PAUSE, DONE
//  is_restart   out  1  1 in RUN, PAUSE (a count sequence is in progress)
//  is_setting   out  1  1 in SET
// BEHAVIOUR
//  - All outputs registered; a pulse sampled at edge N is reflected in the outputs after edge N.
//  - Reset (rst_n=0, asynchronous): state=IDLE, preset=INIT_VALUE, q=INIT_VALUE, is_pause=1,
//    is_restart=0, is_setting=0. Reset mid-run aborts immediately; no partial decrement.
//  - States: IDLE, RUN, PAUSE, DONE, SET (one-hot or binary, implementer's choice).
//  - IDLE:  btn_start->RUN; btn_set->SET.
//  - RUN:   tick_1hz -> q = q-1 (BCD). If q==1 at the tick: q=0 and ->DONE.
//           btn_start->PAUSE; btn_restart->q=preset, IDLE.
//  - PAUSE: tick ignored, q held. btn_start->RUN; btn_restart->q=preset, IDLE.
//  - DONE:  q held at 0, btn_start ignored. btn_restart->q=preset, IDLE; btn_set->SET.
//  - SET:   q shows the preset. btn_inc -> preset = preset+1 (BCD); at MAX_VALUE wraps to 1
//           (0 is never a legal preset). btn_set->q=preset, IDLE. btn_start and btn_restart
//           ignored; tick ignored.
//  - BCD decrement: per-digit borrow; a digit at 0 becomes 9 and borrows from the next digit.
//    Never applied when q==0.
//  - BCD increment: per-digit carry; a digit at 9 becomes 0 and carries. The MAX_VALUE check
//    precedes the carry.
//  - Simultaneous inputs in one cycle; priority btn_restart > btn_set > btn_start > btn_inc >
//    tick_1hz. Only the highest-priority input legal in the current state acts; all others that
//    cycle are dropped (e.g. tick coincident with btn_start in RUN: PAUSE entered, q unchanged).
//  - btn_set in RUN or PAUSE is ignored (restart first).
//  - Inputs are assumed single-cycle; a held level re-triggers every cycle (no edge detect here).
// TESTING
//  1. Reset, INIT_VALUE=8'h30 -> q=8'h30, is_pause=1, is_restart=0, is_setting=0.
//  2. Preset 8'h03; start; 3 ticks -> q 02,01,00; state DONE; is_restart=0; further ticks and
//     btn_start leave q=00.
//  3. Preset 8'h30, RUN; tick -> q=8'h29 (borrow); btn_start -> is_pause=1, is_restart=1;
//     2 ticks -> q stays 29; btn_start; tick -> 28.
//  4. RUN at q=8'h17; btn_restart -> q=8'h30, IDLE, is_pause=1, is_restart=0.
//  5. SET: preset 8'h09; btn_inc -> 8'h10. Preset 8'h99; btn_inc -> 8'h01. btn_set -> IDLE,
//     q=01, is_setting=0.
//  6. RUN at q=8'h05: tick+btn_start same cycle -> PAUSE, q=05. btn_restart+btn_start same
//     cycle -> IDLE, q=preset. rst_n low mid-run -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: BCD countdown-timer core.
// Holds the preset and the running count, sequences IDLE/RUN/PAUSE/DONE/SET
// from one-cycle button pulses and a 1 Hz tick, and drives the registered
// status flags consumed by the LED and display stages.
//
// Input qualification: every input is a single-cycle pulse sampled on the
// rising edge of clk. In any one cycle only the highest-priority input that
// is legal in the current state acts (restart > set > start > inc > tick);
// every other input in that cycle is dropped. A held level re-triggers on
// every cycle.
module countdown_ctrl #(
    parameter int                   DIGITS     = 2,
    parameter logic [4*DIGITS-1:0]  INIT_VALUE = 8'h30,
    parameter logic [4*DIGITS-1:0]  MAX_VALUE  = 8'h99
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_1hz,
    input  logic                  btn_start,
    input  logic                  btn_restart,
    input  logic                  btn_set,
    input  logic                  btn_inc,
    output logic [4*DIGITS-1:0]   q,
    output logic                  is_pause,
    output logic                  is_restart,
    output logic                  is_setting,
    output logic [2:0]            dbg_state
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3,
        S_SET   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   preset_q, preset_d;
    logic [W-1:0]   q_q, q_d;
    logic           is_pause_q, is_pause_d;
    logic           is_restart_q, is_restart_d;
    logic           is_setting_q, is_setting_d;

    // Per-digit BCD decrement: a 0 digit becomes 9 and borrows from the next.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Per-digit BCD increment: a 9 digit becomes 0 and carries into the next.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Next-state, preset and count selection with per-state input priority.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        q_d      = q_q;
        case (state_q)
            S_IDLE: begin
                if (btn_set) begin
                    state_d = S_SET;
                    q_d     = preset_q;
                end else if (btn_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (btn_restart) begin
                    state_d = S_IDLE;
                    q_d     = preset_q;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                end else if (tick_1hz) begin
                    if (q_q == ONE) begin
                        q_d     = ZERO;
                        state_d = S_DONE;
                    end else if (q_q != ZERO) begin
                        q_d = bcd_dec(q_q);
                    end
                end
            end
            S_PAUSE: begin
                if (btn_restart) begin
                    state_d = S_IDLE;
                    q_d     = preset_q;
                end else if (btn_start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (btn_restart) begin
                    state_d = S_IDLE;
                    q_d     = preset_q;
                end else if (btn_set) begin
                    state_d = S_SET;
                    q_d     = preset_q;
                end
            end
            S_SET: begin
                if (btn_set) begin
                    state_d = S_IDLE;
                    q_d     = preset_q;
                end else if (btn_inc) begin
                    // The wrap test comes before the carry so 0 is never a preset.
                    preset_d = (preset_q == MAX_VALUE) ? ONE : bcd_inc(preset_q);
                    q_d      = preset_d;
                end
            end
            default: begin
                state_d = S_IDLE;
                q_d     = preset_q;
            end
        endcase
    end

    // Status flags follow the state being entered so they line up with q.
    always_comb begin
        is_pause_d   = (state_d == S_IDLE) || (state_d == S_PAUSE) || (state_d == S_DONE);
        is_restart_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        is_setting_d = (state_d == S_SET);
    end

    // State, preset, count and flag registers; reset aborts any run at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            preset_q     <= INIT_VALUE;
            q_q          <= INIT_VALUE;
            is_pause_q   <= 1'b1;
            is_restart_q <= 1'b0;
            is_setting_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            preset_q     <= preset_d;
            q_q          <= q_d;
            is_pause_q   <= is_pause_d;
            is_restart_q <= is_restart_d;
            is_setting_q <= is_setting_d;
        end
    end

    assign q          = q_q;
    assign is_pause   = is_pause_q;
    assign is_restart = is_restart_q;
    assign is_setting = is_setting_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed bench for countdown_ctrl with a scoreboard.
// The driver pushes the expected {q, is_pause, is_restart, is_setting} after
// each stimulus edge; the monitor pops and compares on the falling edge.
module tb_countdown_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       btn_start;
    logic       btn_restart;
    logic       btn_set;
    logic       btn_inc;
    logic [7:0] q;
    logic       is_pause;
    logic       is_restart;
    logic       is_setting;
    logic [2:0] dbg_state;

    // Button vector order: {restart, set, start, inc, tick}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] TK   = 5'b00001;
    localparam logic [4:0] INC  = 5'b00010;
    localparam logic [4:0] ST   = 5'b00100;
    localparam logic [4:0] SE   = 5'b01000;
    localparam logic [4:0] RS   = 5'b10000;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    countdown_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .btn_start   (btn_start),
        .btn_restart (btn_restart),
        .btn_set     (btn_set),
        .btn_inc     (btn_inc),
        .q           (q),
        .is_pause    (is_pause),
        .is_restart  (is_restart),
        .is_setting  (is_setting),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [10:0] pack(input logic [7:0] eq, input logic ep, er, es);
        return {eq, ep, er, es};
    endfunction

    // Monitor: compare registered outputs against the oldest expectation
    logic [10:0] mon_exp;
    logic [10:0] mon_act;
    string       mon_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {q, is_pause, is_restart, is_setting};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got q=%h pause=%b restart=%b setting=%b, expected q=%h pause=%b restart=%b setting=%b",
                         mon_name, mon_act[10:3], mon_act[2], mon_act[1], mon_act[0],
                         mon_exp[10:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    // Driver: apply one cycle of buttons, then queue the expected outputs
    task automatic step(input string nm, input logic [4:0] b,
                        input logic [7:0] eq, input logic ep, er, es);
        @(negedge clk);
        btn_restart = b[4];
        btn_set     = b[3];
        btn_start   = b[2];
        btn_inc     = b[1];
        tick_1hz    = b[0];
        @(posedge clk);
        #1;
        btn_restart = 1'b0;
        btn_set     = 1'b0;
        btn_start   = 1'b0;
        btn_inc     = 1'b0;
        tick_1hz    = 1'b0;
        exp_q.push_back(pack(eq, ep, er, es));
        name_q.push_back(nm);
    endtask

    // Pull reset low between edges; outputs must clear before the next edge
    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pack(8'h30, 1'b1, 1'b0, 1'b0));
        name_q.push_back(nm);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        tick_1hz    = 1'b0;
        btn_start   = 1'b0;
        btn_restart = 1'b0;
        btn_set     = 1'b0;
        btn_inc     = 1'b0;

        // Reset values
        exp_q.push_back(pack(8'h30, 1'b1, 1'b0, 1'b0));
        name_q.push_back("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Run, borrow, pause, resume
        step("start_run",     ST,   8'h30, 0, 1, 0);
        step("tick_borrow",   TK,   8'h29, 0, 1, 0);
        step("pause",         ST,   8'h29, 1, 1, 0);
        step("pause_tick1",   TK,   8'h29, 1, 1, 0);
        step("pause_tick2",   TK,   8'h29, 1, 1, 0);
        step("resume",        ST,   8'h29, 0, 1, 0);
        step("tick_28",       TK,   8'h28, 0, 1, 0);
        for (int n = 27; n >= 17; n--) step("run_tick", TK, to_bcd(n), 0, 1, 0);
        step("restart_run",   RS,   8'h30, 1, 0, 0);

        // Coincident inputs and ignored btn_set while running
        step("start_run2",    ST,   8'h30, 0, 1, 0);
        for (int n = 29; n >= 5; n--) step("run_tick2", TK, to_bcd(n), 0, 1, 0);
        step("tick_and_start", TK | ST, 8'h05, 1, 1, 0);
        step("restart_and_start", RS | ST, 8'h30, 1, 0, 0);
        step("start_run3",    ST,   8'h30, 0, 1, 0);
        step("set_in_run",    SE,   8'h30, 0, 1, 0);
        step("set_and_tick",  SE | TK, 8'h29, 0, 1, 0);
        async_reset("async_reset_mid_run");
        step("after_reset",   NONE, 8'h30, 1, 0, 0);

        // Setting mode: carry, wrap at max, ignored inputs
        step("set_over_start", SE | ST, 8'h30, 0, 0, 1);
        for (int n = 31; n <= 99; n++) step("inc", INC, to_bcd(n), 0, 0, 1);
        step("inc_wrap",      INC,  8'h01, 0, 0, 1);
        for (int n = 2; n <= 10; n++) step("inc_b", INC, to_bcd(n), 0, 0, 1);
        step("set_ign_start", ST,   8'h10, 0, 0, 1);
        step("set_ign_restart", RS, 8'h10, 0, 0, 1);
        step("set_ign_tick",  TK,   8'h10, 0, 0, 1);
        step("set_exit",      SE,   8'h10, 1, 0, 0);
        step("idle_ign_inc",  INC,  8'h10, 1, 0, 0);

        // Preset 03, count to zero, DONE behaviour
        step("set_enter",     SE,   8'h10, 0, 0, 1);
        for (int n = 11; n <= 99; n++) step("inc_c", INC, to_bcd(n), 0, 0, 1);
        step("inc_wrap2",     INC,  8'h01, 0, 0, 1);
        step("inc_02",        INC,  8'h02, 0, 0, 1);
        step("inc_03",        INC,  8'h03, 0, 0, 1);
        step("set_exit_03",   SE,   8'h03, 1, 0, 0);
        step("start_03",      ST,   8'h03, 0, 1, 0);
        step("tick_02",       TK,   8'h02, 0, 1, 0);
        step("tick_01",       TK,   8'h01, 0, 1, 0);
        step("tick_done",     TK,   8'h00, 1, 0, 0);
        step("done_tick",     TK,   8'h00, 1, 0, 0);
        step("done_start",    ST,   8'h00, 1, 0, 0);
        step("done_restart_over_set", RS | SE, 8'h03, 1, 0, 0);
        step("start_03b",     ST,   8'h03, 0, 1, 0);
        step("tick_02b",      TK,   8'h02, 0, 1, 0);
        step("tick_01b",      TK,   8'h01, 0, 1, 0);
        step("tick_doneb",    TK,   8'h00, 1, 0, 0);
        step("done_set",      SE,   8'h03, 0, 0, 1);
        step("set_exit_b",    SE,   8'h03, 1, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
